debug_unit: RTL and testbench
=============================

Name: debug_unit

Overview:
- Control and observation front-end upstream of the MIPS pipeline top; drives the pipeline's i_valid (enable) and a pipeline reset pulse.
- Takes one-byte commands from a UART receiver and runs the pipeline continuously or one cycle at a time.
- Dumps PC, cycle count and register file as a byte stream to a UART transmitter.

Parameters:
NB_REG, 32, width of PC, cycle counter and register words
NB_BYTE, 8, UART data width
NB_REG_ADDR, 5, register file debug address width
REGFILE_DEPTH, 32, number of registers dumped

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  NB_BYTE  received command byte
i_rx_done  in  1  one-cycle pulse: i_rx_data valid
o_tx_data  out  NB_BYTE  byte to transmit
o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data
i_tx_done  in  1  one-cycle pulse: transmitter finished previous byte
i_halt  in  1  pipeline executed halt instruction (level)
i_pc  in  NB_REG  current pipeline PC
o_reg_addr  out  NB_REG_ADDR  debug read address into register file
i_reg_data  in  NB_REG  combinational register read data for o_reg_addr
o_valid  out  1  pipeline enable (to pipeline i_valid)
o_pipe_reset  out  1  one-cycle pipeline reset pulse
o_busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, i_reset high at clock edge): state IDLE.
  - Cycle counter = 0, byte index = 0, snapshot registers = 0.
  - o_valid = 0, o_tx_start = 0, o_tx_data = 0, o_reg_addr = 0, o_pipe_reset = 0, o_busy = 0.
  - Reset during any state, including mid-dump, aborts immediately; no further o_tx_start.
- Commands are accepted only in IDLE, on i_rx_done. Bytes received in other states are dropped.
  - 0x01 RUN: go to RUN.
  - 0x02 STEP: go to STEP.
  - 0x03 DUMP: go to DUMP_LOAD.
  - 0x04 CLEAR: o_pipe_reset = 1 for exactly the next cycle; cycle counter cleared; stay IDLE.
  - Any other value: ignored, stay IDLE.
- o_valid is combinational: (state==RUN && !i_halt) || state==STEP.
- Cycle counter increments by 1 every clock with o_valid = 1. It wraps 0xFFFFFFFF -> 0 with no flag.
- RUN: stays in RUN while i_halt = 0. When i_halt is sampled 1, go to DUMP_LOAD; o_valid is already 0 in that cycle.
  - i_halt already 1 on entry: zero cycles execute, immediate dump.
- STEP: exactly one cycle with o_valid = 1, then DUMP_LOAD. Count increases by exactly 1.
- DUMP_LOAD (1 cycle): latch i_pc and the cycle counter into snapshot registers; byte index = 0; go to DUMP_SEND.
- DUMP_SEND (1 cycle): drive o_tx_data = byte[index] and pulse o_tx_start; go to DUMP_WAIT.
- DUMP_WAIT: hold o_tx_data stable until i_tx_done.
  - On i_tx_done: if index == 8+4*REGFILE_DEPTH-1 (135 by default), go to IDLE; else index+1 and return to DUMP_SEND.
  - i_tx_done outside DUMP_WAIT is ignored.
- Byte stream order, each word LSB byte first:
  - bytes 0-3: snapshot PC
  - bytes 4-7: snapshot cycle count
  - bytes 8..: reg 0 through reg REGFILE_DEPTH-1
- Register bytes: o_reg_addr = (index-8)>>2 during SEND/WAIT for index >= 8. Byte = i_reg_data[8*((index-8)%4) +: 8], sampled in DUMP_SEND and registered into o_tx_data.
- Exactly one o_tx_start per byte; minimum 2 cycles between consecutive o_tx_start pulses.

Test Plan:
- Reset, rx 0x02, tx_done returned 2 cycles after each start -> o_valid high exactly 1 cycle; 136 start pulses; bytes 4-7 = 01 00 00 00; o_busy low after last done.
- Rx 0x01, i_halt rises after 10 o_valid cycles -> o_valid deasserts that cycle; dumped count bytes = 0A 00 00 00; PC bytes = i_pc value at halt (e.g. 0x00000028 -> 28 00 00 00).
- Register model reg[n] = 0xA0B0C0n0, rx 0x03 -> bytes 8-11 = 00 C0 B0 A0; byte 135 = A0; o_reg_addr = 31 for last word.
- Withhold i_tx_done for 50 cycles mid-dump -> o_tx_data stable, no extra o_tx_start; byte stream resumes in order.
- Rx 0x7F and 0x02 during RUN -> both ignored, no state change. Rx 0x04 in IDLE -> one-cycle o_pipe_reset; next dump count = 0.
- i_reset asserted after 20 dump bytes -> next cycle all outputs at reset values; a new 0x03 restarts the dump from byte 0.

Source files
------------

// File: rtl/debug_unit.sv
`default_nettype none
// ============================================================================
// Module      : debug_unit
// Description : UART-driven run/step control and PC/count/regfile dump front-end
// Revision    : 1.0
// ============================================================================
module debug_unit #(
    parameter int NB_REG        = 32,
    parameter int NB_BYTE       = 8,
    parameter int NB_REG_ADDR   = 5,
    parameter int REGFILE_DEPTH = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_BYTE-1:0]     i_rx_data,
    input  logic                   i_rx_done,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    input  logic                   i_halt,
    input  logic [NB_REG-1:0]      i_pc,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    input  logic [NB_REG-1:0]      i_reg_data,
    output logic                   o_valid,
    output logic                   o_pipe_reset,
    output logic                   o_busy
);

    localparam int                 IDX_W    = $clog2(8 + 4 * REGFILE_DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(8 + 4 * REGFILE_DEPTH - 1);
    localparam logic [IDX_W-1:0]   REG_BASE = IDX_W'(8);
    localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h01);
    localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h02);
    localparam logic [NB_BYTE-1:0] CMD_DUMP  = NB_BYTE'(8'h03);
    localparam logic [NB_BYTE-1:0] CMD_CLEAR = NB_BYTE'(8'h04);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_STEP      = 3'd2,
        S_DUMP_LOAD = 3'd3,
        S_DUMP_SEND = 3'd4,
        S_DUMP_WAIT = 3'd5
    } state_t;

    state_t             state_q;
    logic [NB_REG-1:0]  cycle_cnt_q;
    logic [NB_REG-1:0]  pc_snap_q;
    logic [NB_REG-1:0]  cnt_snap_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NB_BYTE-1:0] tx_data_q;
    logic               tx_start_q;
    logic               pipe_reset_q;

    logic [NB_REG-1:0]  word_d;
    logic [NB_REG-1:0]  word_shift_d;
    logic [NB_BYTE-1:0] tx_byte_d;
    logic [IDX_W-1:0]   reg_off_d;
    logic               dumping_d;

    // Every word goes out LSB first, so the byte lane is simply idx[1:0].
    always_comb begin
        reg_off_d = (idx_q - REG_BASE) >> 2;
        if (idx_q < IDX_W'(4)) begin
            word_d = pc_snap_q;
        end else if (idx_q < REG_BASE) begin
            word_d = cnt_snap_q;
        end else begin
            word_d = i_reg_data;
        end
        word_shift_d = word_d >> {idx_q[1:0], 3'b000};
        tx_byte_d    = word_shift_d[NB_BYTE-1:0];
    end

    assign dumping_d    = (state_q == S_DUMP_SEND) || (state_q == S_DUMP_WAIT);
    assign o_reg_addr   = (dumping_d && idx_q >= REG_BASE) ? reg_off_d[NB_REG_ADDR-1:0] : '0;
    assign o_valid      = ((state_q == S_RUN) && !i_halt) || (state_q == S_STEP);
    assign o_busy       = (state_q != S_IDLE);
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_pipe_reset = pipe_reset_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            cycle_cnt_q  <= '0;
            pc_snap_q    <= '0;
            cnt_snap_q   <= '0;
            idx_q        <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            pipe_reset_q <= 1'b0;
        end else begin
            tx_start_q   <= 1'b0;
            pipe_reset_q <= 1'b0;
            if (o_valid) begin
                cycle_cnt_q <= cycle_cnt_q + NB_REG'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (i_rx_done) begin
                        case (i_rx_data)
                            CMD_RUN:  state_q <= S_RUN;
                            CMD_STEP: state_q <= S_STEP;
                            CMD_DUMP: state_q <= S_DUMP_LOAD;
                            CMD_CLEAR: begin
                                pipe_reset_q <= 1'b1;
                                cycle_cnt_q  <= '0;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_RUN: begin
                    if (i_halt) begin
                        state_q <= S_DUMP_LOAD;
                    end
                end
                S_STEP: begin
                    state_q <= S_DUMP_LOAD;
                end
                S_DUMP_LOAD: begin
                    pc_snap_q  <= i_pc;
                    cnt_snap_q <= cycle_cnt_q;
                    idx_q      <= '0;
                    state_q    <= S_DUMP_SEND;
                end
                S_DUMP_SEND: begin
                    tx_data_q  <= tx_byte_d;
                    tx_start_q <= 1'b1;
                    state_q    <= S_DUMP_WAIT;
                end
                S_DUMP_WAIT: begin
                    if (i_tx_done) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= S_DUMP_SEND;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_unit
// Description : Randomized self-checking bench for debug_unit with a stream model
// Revision    : 1.0
// ============================================================================
module tb_debug_unit;

    localparam int DEPTH  = 32;
    localparam int NBYTES = 8 + 4 * DEPTH;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_done = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done = 1'b0;
    logic        i_halt = 1'b0;
    logic [31:0] i_pc = '0;
    logic [4:0]  o_reg_addr;
    logic [31:0] i_reg_data;
    logic        o_valid;
    logic        o_pipe_reset;
    logic        o_busy;

    logic [31:0] regs [DEPTH];
    assign i_reg_data = regs[o_reg_addr];

    always #5 clk = ~clk;

    debug_unit #(
        .NB_REG(32), .NB_BYTE(8), .NB_REG_ADDR(5), .REGFILE_DEPTH(DEPTH)
    ) dut (
        .i_clock(clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .i_halt(i_halt), .i_pc(i_pc),
        .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
        .o_valid(o_valid), .o_pipe_reset(o_pipe_reset), .o_busy(o_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the pipeline counter should read, and what was received.
    logic [31:0] m_cnt = '0;
    logic [7:0]  rx_q [$];
    int valid_cnt = 0, pr_cnt = 0, start_cnt = 0;
    int stable_err = 0, extra_err = 0, hold_at = -1;
    logic [4:0] last_addr = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // UART transmitter stand-in: answers each start with a done pulse after a delay.
    initial begin : tx_responder
        bit         pend = 1'b0;
        logic [7:0] pend_byte = '0;
        int         wait_cnt = 0;
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            if (i_reset) begin
                pend = 1'b0;
            end else begin
                if (o_valid) valid_cnt++;
                if (o_pipe_reset) pr_cnt++;
                if (o_tx_start) start_cnt++;
                if (pend) begin
                    if (o_tx_data !== pend_byte) stable_err++;
                    if (o_tx_start) extra_err++;
                    wait_cnt--;
                    if (wait_cnt <= 0) begin
                        i_tx_done = 1'b1;
                        pend = 1'b0;
                    end
                end else if (o_tx_start) begin
                    rx_q.push_back(o_tx_data);
                    last_addr = o_reg_addr;
                    pend = 1'b1;
                    pend_byte = o_tx_data;
                    wait_cnt = (rx_q.size() == hold_at) ? 50 : int'($urandom_range(1, 4));
                end
            end
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (o_busy && c < 20000) begin
            tick();
            c++;
        end
        if (o_busy) chk("timeout_busy", 1, 0);
        tick(); tick();
    endtask

    task automatic randomize_env();
        for (int k = 0; k < DEPTH; k++) regs[k] = $urandom;
        i_pc = $urandom;
    endtask

    function automatic logic [31:0] rx_word(input int base);
        return {rx_q[base+3], rx_q[base+2], rx_q[base+1], rx_q[base]};
    endfunction

    // Expected stream: PC, then count, then every register, each word LSB byte first.
    task automatic check_dump(input string tag);
        logic [7:0]  exp_q [$];
        logic [31:0] words [$];
        int mism = 0;
        words.push_back(i_pc);
        words.push_back(m_cnt);
        for (int k = 0; k < DEPTH; k++) words.push_back(regs[k]);
        foreach (words[w]) for (int b = 0; b < 4; b++) exp_q.push_back(8'((words[w] >> (8 * b)) & 32'hFF));
        chk({tag, "_len"}, rx_q.size(), NBYTES);
        for (int k = 0; k < NBYTES && k < rx_q.size(); k++) if (rx_q[k] !== exp_q[k]) mism++;
        chk({tag, "_bytes"}, mism, 0);
        rx_q.delete();
    endtask

    task automatic do_run(input int n, input bit inject);
        valid_cnt = 0;
        i_halt = (n == 0);
        send_cmd(8'h01);
        for (int i = 0; i < n; i++) begin
            if (inject && i == 1) begin i_rx_data = 8'h7F; i_rx_done = 1'b1; end
            else if (inject && i == 3) begin i_rx_data = 8'h02; i_rx_done = 1'b1; end
            else i_rx_done = 1'b0;
            tick();
        end
        i_rx_done = 1'b0;
        i_halt = 1'b1;
        #1 chk("run_valid_low_at_halt", o_valid, 0);
        m_cnt += 32'(n);
        wait_idle();
        i_halt = 1'b0;
        chk("run_valid_cycles", valid_cnt, n);
    endtask

    initial begin : main
        int s0;
        logic [7:0] junk;
        for (int k = 0; k < DEPTH; k++) regs[k] = '0;
        tick(); tick(); tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_tx_start", o_tx_start, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_reg_addr", o_reg_addr, 0);
        chk("rst_pipe_reset", o_pipe_reset, 0);
        chk("rst_busy", o_busy, 0);
        i_reset = 1'b0;
        tick();

        // Single step
        randomize_env();
        valid_cnt = 0; s0 = start_cnt;
        send_cmd(8'h02);
        wait_idle();
        m_cnt += 1;
        chk("step_valid_cycles", valid_cnt, 1);
        chk("step_starts", start_cnt - s0, NBYTES);
        chk("step_cnt_word", rx_word(4), 32'h1);
        chk("step_busy_low", o_busy, 0);
        check_dump("step");

        // Run until halt after 10 cycles; stray bytes during RUN are dropped
        randomize_env();
        i_pc = 32'h28;
        do_run(10, 1'b1);
        chk("run_pc_word", rx_word(0), 32'h28);
        chk("run_cnt_word", rx_word(4), 32'd11);
        check_dump("run10");

        // Fixed register pattern dump with a 50-cycle withheld done
        for (int k = 0; k < DEPTH; k++) regs[k] = 32'hA0B0C000 | (32'(k) << 4);
        hold_at = 30;
        send_cmd(8'h03);
        wait_idle();
        hold_at = -1;
        chk("dump_reg0_word", rx_word(8), 32'hA0B0C000);
        chk("dump_last_byte", rx_q[NBYTES-1], 8'hA0);
        chk("dump_last_addr", last_addr, 5'd31);
        check_dump("dump_fixed");

        // Clear then dump: count reads zero
        pr_cnt = 0;
        send_cmd(8'h04);
        tick(); tick();
        chk("clear_pulse_cycles", pr_cnt, 1);
        chk("clear_busy", o_busy, 0);
        m_cnt = '0;
        send_cmd(8'h03);
        wait_idle();
        chk("clear_cnt_word", rx_word(4), 32'h0);
        check_dump("clear");

        // Halt already high on entry
        randomize_env();
        do_run(0, 1'b0);
        check_dump("run0");

        // Reset mid-dump
        randomize_env();
        send_cmd(8'h03);
        for (int c = 0; c < 2000 && rx_q.size() < 20; c++) tick();
        chk("mid_dump_reached", rx_q.size() >= 20, 1);
        i_reset = 1'b1;
        tick();
        s0 = start_cnt;
        chk("mrst_valid", o_valid, 0);
        chk("mrst_tx_start", o_tx_start, 0);
        chk("mrst_tx_data", o_tx_data, 0);
        chk("mrst_reg_addr", o_reg_addr, 0);
        chk("mrst_pipe_reset", o_pipe_reset, 0);
        chk("mrst_busy", o_busy, 0);
        tick();
        i_reset = 1'b0;
        m_cnt = '0;
        rx_q.delete();
        repeat (10) tick();
        chk("mrst_no_more_starts", start_cnt - s0, 0);
        send_cmd(8'h03);
        wait_idle();
        check_dump("after_reset");

        // Random command mix
        for (int it = 0; it < 10; it++) begin
            randomize_env();
            case ($urandom_range(0, 4))
                0: begin
                    valid_cnt = 0;
                    send_cmd(8'h02);
                    wait_idle();
                    m_cnt += 1;
                    chk("rnd_step_valid", valid_cnt, 1);
                    check_dump("rnd_step");
                end
                1: begin
                    do_run(int'($urandom_range(0, 25)), 1'b0);
                    check_dump("rnd_run");
                end
                2: begin
                    pr_cnt = 0;
                    send_cmd(8'h04);
                    tick(); tick();
                    m_cnt = '0;
                    chk("rnd_clear_pulse", pr_cnt, 1);
                end
                3: begin
                    do junk = 8'($urandom_range(0, 255)); while (junk inside {[8'd1:8'd4]});
                    send_cmd(junk);
                    tick(); tick();
                    chk("rnd_junk_idle", o_busy, 0);
                end
                default: begin
                    send_cmd(8'h03);
                    wait_idle();
                    check_dump("rnd_dump");
                end
            endcase
        end

        chk("tx_data_stable", stable_err, 0);
        chk("no_extra_starts", extra_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
